native_mem_responder: RTL and testbench

Responder for the picorv32 native memory interface (mem_valid / mem_ready handshake). It replaces a hard-wired mem_ready = 1 with a real handshake. Each request is accepted, held for a programmable number of wait states, then completed with a one-cycle mem_ready pulse, backed by a byte-strobed word RAM. It sits between the picorv32 core and on-chip storage in design_top, so the core can be exercised against non-zero memory latency and out-of-range accesses.

---
 rtl/native_mem_pkg.sv | 25 ++
 rtl/native_mem_array.sv | 34 +++
 rtl/native_mem_responder.sv | 144 ++++++++++++++
 tb/tb_native_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/native_mem_pkg.sv
// Shared types and address helpers for the native-interface memory responder.
package native_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 4;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 5'd2) < words);
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 5'd2;
  endfunction

endpackage

// File: rtl/native_mem_array.sv
// Byte-strobed word RAM: one registered read port, one write port, no reset.
module native_mem_array #(
  parameter int unsigned WORDS = 32
) (
  input  logic                     clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(WORDS)-1:0] i_rd_idx,
  output logic [31:0]              o_rd_q,
  input  logic                     i_wr_en,
  input  logic [$clog2(WORDS)-1:0] i_wr_idx,
  input  logic [31:0]              i_wr_data,
  input  logic [3:0]               i_wr_be
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_q;

  // Registered read and per-lane write.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_q <= r_mem[i_rd_idx];
    end
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign o_rd_q = r_q;

endmodule

// File: rtl/native_mem_responder.sv
// picorv32 native-interface responder: accepts a request, waits LATENCY cycles,
// then answers with a one-cycle mem_ready backed by a word RAM.
module native_mem_responder
  import native_mem_pkg::*;
#(
  parameter int unsigned WORDS     = 32,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err_oor,
  output logic        err_instr,
  input  logic        clr_err
);

  localparam int unsigned    AW      = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_instr, r_ready, r_rd_ok, r_err_oor, r_err_instr;
  logic [31:0]      w_cur_addr, w_ram_q;
  logic [3:0]       w_cur_wstrb;
  logic             w_cur_in_range, w_lat_in_range, w_enter_resp, w_wr_en;
  logic [AW-1:0]    w_rd_idx, w_wr_idx;

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_cnt_nxt   = LAT_C;
          w_state_nxt = (LAT_C == '0) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= CNT_ONE) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A zero-latency request enters RESP straight from IDLE, before the latch is loaded.
  assign w_cur_addr     = (r_state == S_IDLE) ? mem_addr  : r_addr;
  assign w_cur_wstrb    = (r_state == S_IDLE) ? mem_wstrb : r_wstrb;
  assign w_cur_in_range = addr_in_range(w_cur_addr, BASE_ADDR, WORDS);
  assign w_lat_in_range = addr_in_range(r_addr, BASE_ADDR, WORDS);
  assign w_rd_idx       = AW'(word_index(w_cur_addr, BASE_ADDR));
  assign w_wr_idx       = AW'(word_index(r_addr, BASE_ADDR));
  assign w_enter_resp   = (w_state_nxt == S_RESP);
  assign w_wr_en        = (r_state == S_RESP) && w_lat_in_range && (r_wstrb != 4'b0000);

  // State, counter and registered response flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_enter_resp;
      r_rd_ok <= w_enter_resp && w_cur_in_range && (w_cur_wstrb == 4'b0000);
    end
  end

  // Request latch, loaded on acceptance only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'b0000;
      r_instr <= 1'b0;
    end else if ((r_state == S_IDLE) && mem_valid) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
      r_instr <= mem_instr;
    end
  end

  // Sticky error flags; a new out-of-range completion wins over clr_err.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_oor   <= 1'b0;
      r_err_instr <= 1'b0;
    end else if ((r_state == S_RESP) && !w_lat_in_range) begin
      r_err_oor   <= 1'b1;
      r_err_instr <= r_instr;
    end else if (clr_err) begin
      r_err_oor   <= 1'b0;
      r_err_instr <= 1'b0;
    end
  end

  native_mem_array #(.WORDS(WORDS)) u_array (
    .clk       (clk),
    .i_rd_en   (w_enter_resp),
    .i_rd_idx  (w_rd_idx),
    .o_rd_q    (w_ram_q),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (r_wdata),
    .i_wr_be   (r_wstrb)
  );

  assign mem_ready = r_ready;
  assign mem_rdata = r_rd_ok ? w_ram_q : 32'h0;
  assign err_oor   = r_err_oor;
  assign err_instr = r_err_instr;

endmodule

// File: tb/tb_native_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 0, 3) sharing the request bus.
module tb_native_mem_responder;

  localparam int D1 = 0;  // LATENCY=1, BASE 0
  localparam int D0 = 1;  // LATENCY=0, BASE 0
  localparam int D3 = 2;  // LATENCY=3, BASE 0x1000

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  valid;
  logic        instr, clr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [2:0]  rdy, eoor, einstr;
  logic [31:0] rd [3];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  native_mem_responder #(.WORDS(32), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_d1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[D1]), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[D1]),
    .mem_rdata(rd[D1]), .err_oor(eoor[D1]), .err_instr(einstr[D1]), .clr_err(clr));

  native_mem_responder #(.WORDS(32), .LATENCY(0), .BASE_ADDR(32'h0000_0000)) u_d0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[D0]), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[D0]),
    .mem_rdata(rd[D0]), .err_oor(eoor[D0]), .err_instr(einstr[D0]), .clr_err(clr));

  native_mem_responder #(.WORDS(32), .LATENCY(3), .BASE_ADDR(32'h0000_1000)) u_d3 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[D3]), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[D3]),
    .mem_rdata(rd[D3]), .err_oor(eoor[D3]), .err_instr(einstr[D3]), .clr_err(clr));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full handshake; lat = cycles from the accepting edge to mem_ready (0 on timeout).
  task automatic mem_req(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins,
                         output int lat, output logic [31:0] q);
    lat = 0;
    q   = 32'hFFFF_FFFF;
    @(negedge clk);
    addr  = a;
    wdata = d;
    wstrb = s;
    instr = ins;
    valid[sel] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rdy[sel]) begin
        lat = i;
        q   = rd[sel];
        break;
      end
    end
    valid[sel] = 1'b0;
    @(posedge clk);
    #1;
    check_val("ready_pulse", {31'b0, rdy[sel]}, 32'h0);
    check_val("rdata_idle", rd[sel], 32'h0);
  endtask

  initial begin
    int          lat, i1, i2, n_rdy;
    logic [31:0] q;
    resetn = 1'b0;
    valid  = 3'b000;
    instr  = 1'b0;
    clr    = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    wstrb  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {29'b0, rdy}, 32'h0);
    check_val("rst_rdata", rd[D1], 32'h0);
    check_val("rst_err_oor", {29'b0, eoor}, 32'h0);
    check_val("rst_err_instr", {29'b0, einstr}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Write then read, LATENCY=1.
    mem_req(D1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, q);
    check_val("wr_lat", lat, 32'd2);
    check_val("wr_rdata", q, 32'h0);
    mem_req(D1, 32'h10, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("rd_lat", lat, 32'd2);
    check_val("rd_data", q, 32'hDEAD_BEEF);

    // Byte strobes 0101 over 0x11223344.
    mem_req(D1, 32'h08, 32'h1122_3344, 4'hF, 1'b0, lat, q);
    mem_req(D1, 32'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, q);
    mem_req(D1, 32'h08, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("strb_data", q, 32'h11BB_33DD);
    check_val("strb_err", {31'b0, eoor[D1]}, 32'h0);

    // Zero latency: single response and back-to-back period.
    mem_req(D0, 32'h04, 32'h0BAD_F00D, 4'hF, 1'b0, lat, q);
    check_val("lat0_wr_lat", lat, 32'd1);
    mem_req(D0, 32'h04, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("lat0_rd_lat", lat, 32'd1);
    check_val("lat0_rd_data", q, 32'h0BAD_F00D);
    i1 = 0;
    i2 = 0;
    @(negedge clk);
    addr  = 32'h04;
    wstrb = 4'h0;
    valid[D0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rdy[D0]) begin
        if (i1 == 0) i1 = i;
        else if (i2 == 0) i2 = i;
      end
      if (i2 != 0) break;
    end
    valid[D0] = 1'b0;
    check_val("lat0_first", i1, 32'd1);
    check_val("lat0_period", i2 - i1, 32'd2);
    @(posedge clk);
    #1;

    // Out of range on BASE 0x1000.
    mem_req(D3, 32'h107C, 32'h0A0B_0C0D, 4'hF, 1'b0, lat, q);
    check_val("lat3_lat", lat, 32'd4);
    mem_req(D3, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, lat, q);
    check_val("inrange_err", {31'b0, eoor[D3]}, 32'h0);
    mem_req(D3, 32'h1080, 32'h0, 4'h0, 1'b1, lat, q);
    check_val("oor_lat", lat, 32'd4);
    check_val("oor_rdata", q, 32'h0);
    check_val("oor_err", {31'b0, eoor[D3]}, 32'h1);
    check_val("oor_instr", {31'b0, einstr[D3]}, 32'h1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr_err_oor", {31'b0, eoor[D3]}, 32'h0);
    check_val("clr_err_instr", {31'b0, einstr[D3]}, 32'h0);
    mem_req(D3, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, q);
    check_val("oor_wr_rdata", q, 32'h0);
    check_val("oor_wr_err", {31'b0, eoor[D3]}, 32'h1);
    check_val("oor_wr_instr", {31'b0, einstr[D3]}, 32'h0);
    mem_req(D3, 32'h107C, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("oor_wr_top", q, 32'h0A0B_0C0D);
    mem_req(D3, 32'h1000, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("oor_wr_base", q, 32'h1234_5678);

    // Abort during the second WAIT cycle of a write.
    mem_req(D3, 32'h1010, 32'h5566_7788, 4'hF, 1'b0, lat, q);
    @(negedge clk);
    addr  = 32'h1010;
    wdata = 32'hCAFE_F00D;
    wstrb = 4'hF;
    valid[D3] = 1'b1;
    n_rdy = 0;
    @(posedge clk);
    #1;
    n_rdy += int'(rdy[D3]);
    @(posedge clk);
    #1;
    n_rdy += int'(rdy[D3]);
    valid[D3] = 1'b0;
    @(posedge clk);
    #1;
    n_rdy += int'(rdy[D3]);
    check_val("abort_no_ready", n_rdy, 32'd0);
    mem_req(D3, 32'h1010, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("abort_next_lat", lat, 32'd4);
    check_val("abort_ram", q, 32'h5566_7788);

    // Reset during WAIT of a write to 0x00.
    mem_req(D1, 32'h00, 32'h0102_0304, 4'hF, 1'b0, lat, q);
    mem_req(D1, 32'h200, 32'h0, 4'h0, 1'b1, lat, q);
    check_val("pre_rst_err", {30'b0, eoor[D1], einstr[D1]}, 32'h3);
    @(negedge clk);
    addr  = 32'h00;
    wdata = 32'hFFFF_FFFF;
    wstrb = 4'hF;
    valid[D1] = 1'b1;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_mid_ready", {31'b0, rdy[D1]}, 32'h0);
    @(posedge clk);
    #1;
    check_val("rst_hold_ready", {31'b0, rdy[D1]}, 32'h0);
    valid[D1] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_val("rst_mid_err", {30'b0, eoor[D1], einstr[D1]}, 32'h0);
    mem_req(D1, 32'h00, 32'h0, 4'h0, 1'b0, lat, q);
    check_val("rst_mid_lat", lat, 32'd2);
    check_val("rst_mid_ram", q, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
